tinymind_run_ctrl: RTL
======================

# tinymind_run_ctrl

Run controller driving the `tinymind` core's reset and consuming its `done_r` completion flag in silicon, the in-design counterpart of the bench sequence. On `start` it holds the core in reset for a fixed count, releases it, and waits for a rising edge on `done_r`. It repeats for a configured number of passes, then reports completion. A watchdog flags a core that never finishes.

## Interface
- `NUM_PASSES`, default 2: passes per run (≥1).
- `RESET_CYCLES`, default 5: cycles `core_rst_n` is held low per pass (≥1).
- `TIMEOUT`, default 64: maximum cycles in RUN without a `done_r` rise (≥2).
- `clk`  in  1: single clock; `done_r` is synchronous to it.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begins a run; sampled only in IDLE, FINISH or ERROR.
- `done_r`  in  1: completion flag from the core.
- `core_rst_n`  out  1: registered active-low reset to the core.
- `busy`  out  1: high in HOLD and RUN.
- `pass_cnt`  out  $clog2(NUM_PASSES+1): completed passes in the current run.
- `all_done`  out  1: all passes completed; sticky until the next `start`.
- `timeout_err`  out  1: watchdog expired; sticky until the next `start`.

## Operation
- All outputs are registered. Reset values: `core_rst_n`=0, `busy`=0, `pass_cnt`=0, `all_done`=0, `timeout_err`=0. Internal: state=IDLE, `done_q`=0, counters=0.
- `done_q` samples `done_r` every cycle. The rise condition is `done_r & ~done_q`. A rise is acted on only in RUN.
- IDLE: `core_rst_n`=0.
  - `start`=1 → HOLD.
  - Clears `pass_cnt`, `all_done`, `timeout_err` and the hold counter.
- HOLD: `core_rst_n`=0 and the hold counter increments each cycle.
  - After RESET_CYCLES cycles in HOLD → RUN.
  - `core_rst_n`=1 and the watchdog is cleared on the same edge.
- RUN: `core_rst_n`=1 and the watchdog increments each cycle.
  - On a rise, `pass_cnt` increments.
  - If the new count is below NUM_PASSES → HOLD, with `core_rst_n`=0 on that edge.
  - If the new count equals NUM_PASSES → FINISH with `all_done`=1.
  - If the watchdog reaches TIMEOUT with no rise → ERROR with `timeout_err`=1 and `core_rst_n`=0.
- FINISH: `core_rst_n` stays 1, so the core is left in its done state.
  - `start`=1 → HOLD, with the same clears as from IDLE.
- ERROR: `core_rst_n`=0, and `pass_cnt` keeps its last value.
  - `start`=1 → HOLD, with the same clears as from IDLE.
- `start` is ignored in HOLD and RUN.
- A level-high `done_r` with no 0→1 transition in RUN never counts.
- Simultaneous rise and watchdog expiry: the rise wins, and no error is flagged.
- A `done_r` rise during HOLD, IDLE, FINISH or ERROR is ignored and does not increment `pass_cnt`.
- `pass_cnt` saturates at NUM_PASSES; no wrap is possible because RUN exits on reaching it.
- Asserting `rst_n` mid-run immediately forces all reset values, including `core_rst_n`=0.

## Timing
- Latency is measured from the edge E0 that samples `start`=1:
  - `core_rst_n` is low for edges E0..E0+RESET_CYCLES-1.
  - `core_rst_n` goes high at edge E0+RESET_CYCLES.
- A rise sampled at edge Ek updates `pass_cnt` and the state at Ek.
  - The next pass's `core_rst_n` low starts at Ek.
  - Release follows RESET_CYCLES edges later.
- Watchdog: ERROR is entered at the TIMEOUT-th RUN edge without a rise.
- `busy` tracks the state, with the same-edge update as the state register.
- On `rst_n` deassertion, the state is IDLE from the first clock edge.

## Test plan
- Use a behavioural core whose `done_r` rises 14 cycles after release.
  - With NUM_PASSES=2 and RESET_CYCLES=5, pulse `start`.
  - Required: `core_rst_n` low exactly 5 cycles per pass.
  - Required: `pass_cnt` goes 1 then 2, `all_done`=1, `busy`=0, `core_rst_n`=1 in FINISH.
- Integrate with `tinymind` (MAX_VALUE=14) and run 2 passes.
  - Required: `all_done`=1, `timeout_err`=0.
  - Required: each pass begins with the core's `done_r` observed low.
- Use a core model that never asserts `done_r`, with TIMEOUT=64.
  - Required: `timeout_err`=1 exactly 64 cycles after release.
  - Required: `core_rst_n`=0, `pass_cnt`=0, `busy`=0.
- Make the rise coincide with the watchdog's final cycle (rise at release+63, TIMEOUT=64).
  - Required: the pass counts and `timeout_err` stays 0.
- Hold `done_r`=1 through release, then toggle `done_r` during HOLD.
  - Required: neither counts; only a genuine 0→1 transition in RUN increments `pass_cnt`.
- Assert `rst_n` mid-RUN of pass 1, release it, then pulse `start`.
  - Required: outputs return to reset values immediately.
  - Required: the new run completes both passes normally.
  - Required: `start` pulses during HOLD and RUN have no effect.

Source files
------------

// File: rtl/tinymind_run_ctrl.sv
// Run controller for the tinymind core: pulses the core reset for a fixed
// count, waits for a done_r rise, repeats for NUM_PASSES passes, with a watchdog.
module tinymind_run_ctrl #(
  parameter int NUM_PASSES   = 2,
  parameter int RESET_CYCLES = 5,
  parameter int TIMEOUT      = 64,
  localparam int PW = $clog2(NUM_PASSES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          done_r,
  output logic          core_rst_n,
  output logic          busy,
  output logic [PW-1:0] pass_cnt,
  output logic          all_done,
  output logic          timeout_err,
  output logic [2:0]    state_dbg
);

  // start is a level sampled only in IDLE/FINISH/ERROR (no handshake back);
  // done_r is a level whose 0->1 transition, seen in RUN, completes a pass.

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HOLD   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] WD_LAST   = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] NP        = PW'(NUM_PASSES);

  logic [2:0]    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
  logic [PW-1:0] pass_cnt_q, pass_cnt_d;
  logic [PW-1:0] pass_next;
  logic          done_q, done_d;
  logic          core_rst_n_q, core_rst_n_d;
  logic          busy_q, busy_d;
  logic          all_done_q, all_done_d;
  logic          timeout_err_q, timeout_err_d;
  logic          rise;

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    pass_cnt_d    = pass_cnt_q;
    core_rst_n_d  = core_rst_n_q;
    all_done_d    = all_done_q;
    timeout_err_d = timeout_err_q;
    done_d        = done_r;
    rise          = done_r & ~done_q;
    pass_next     = pass_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        core_rst_n_d  = 1'b0;
        pass_cnt_d    = '0;
        all_done_d    = 1'b0;
        timeout_err_d = 1'b0;
        hold_cnt_d    = '0;
        if (start) state_d = S_HOLD;
      end
      S_HOLD: begin
        core_rst_n_d = 1'b0;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d      = S_RUN;
          core_rst_n_d = 1'b1;
          wd_cnt_d     = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        core_rst_n_d = 1'b1;
        wd_cnt_d     = wd_cnt_q + 1'b1;
        // A rise on the watchdog's last edge still counts as a completed pass.
        if (rise) begin
          pass_cnt_d = pass_next;
          if (pass_next == NP) begin
            state_d    = S_FINISH;
            all_done_d = 1'b1;
          end else begin
            state_d      = S_HOLD;
            core_rst_n_d = 1'b0;
            hold_cnt_d   = '0;
          end
        end else if (wd_cnt_q == WD_LAST) begin
          state_d       = S_ERROR;
          timeout_err_d = 1'b1;
          core_rst_n_d  = 1'b0;
        end
      end
      S_FINISH, S_ERROR: begin
        if (start) begin
          state_d       = S_HOLD;
          core_rst_n_d  = 1'b0;
          pass_cnt_d    = '0;
          all_done_d    = 1'b0;
          timeout_err_d = 1'b0;
          hold_cnt_d    = '0;
        end
      end
      default: begin
        state_d      = S_IDLE;
        core_rst_n_d = 1'b0;
      end
    endcase

    busy_d = (state_d == S_HOLD) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      hold_cnt_q    <= '0;
      wd_cnt_q      <= '0;
      pass_cnt_q    <= '0;
      done_q        <= 1'b0;
      core_rst_n_q  <= 1'b0;
      busy_q        <= 1'b0;
      all_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      pass_cnt_q    <= pass_cnt_d;
      done_q        <= done_d;
      core_rst_n_q  <= core_rst_n_d;
      busy_q        <= busy_d;
      all_done_q    <= all_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign core_rst_n  = core_rst_n_q;
  assign busy        = busy_q;
  assign pass_cnt    = pass_cnt_q;
  assign all_done    = all_done_q;
  assign timeout_err = timeout_err_q;
  assign state_dbg   = state_q;

endmodule
